// File: rtl/serial_subtractor_pkg.sv
// Shared state encoding for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: dout = x - y - bi, bo = borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic dout,
    output logic bo
);

    assign dout = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = a - b - bin, LSB first, one bit per clock.
// Result registered in DONE; a new start may be accepted on the DONE edge.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic             cell_d;
    logic             cell_b;
    logic             load;
    logic             shift;
    logic             finish;

    full_subtractor u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bi   (br),
        .dout (cell_d),
        .bo   (cell_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The DONE edge doubles as an accept edge so back-to-back ops skip IDLE.
    always_comb begin
        load   = 1'b0;
        shift  = 1'b0;
        finish = 1'b0;
        case (state)
            IDLE:    load = start;
            SHIFT:   shift = 1'b1;
            DONE: begin
                load   = start;
                finish = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            br    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
        end else if (shift) begin
            res  <= {cell_d, res[WIDTH-1:1]};
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            br   <= cell_b;
            cnt  <= cnt + CW'(1);
        end
    end

    // Operand MSBs are kept aside because the shift registers are consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            d    <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                busy <= 1'b1;
            end else if (finish) begin
                busy <= 1'b0;
            end
            if (finish) begin
                d    <= res;
                bout <= br;
                ovf  <= (a_msb ^ b_msb) & (res[WIDTH-1] ^ a_msb);
            end
        end
    end

endmodule
